ib_lut_loader: RTL and testbench

- Front-end controller for one single-port IB LUT memory bank (`QUAN_SIZE`-bit entries, `PAGE_NUM` pages, synchronous write, registered read that only happens when write enable is low).
- Load side: accepts packed LUT words on a valid/ready stream, serialises them into per-entry write strobes, and flags completion once every page is written.
- Lookup side: once loaded, serves pipelined read requests with fixed 2-cycle latency.
- Sits between the decoder's LUT-configuration bus / lookup requesters and the memory bank.

---
 rtl/ib_lut_loader.sv | 188 ++++++++++++++++++
 tb/tb_ib_lut_loader.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ib_lut_loader.sv
// ---------------------------------------------------------------------------
// ib_lut_loader
//
// Front-end controller for one single-port IB LUT memory bank.
//   * Load side: packed LUT words arrive on a valid/ready stream. Each word is
//     split into ENTRY_PER_WORD entries, which are written one per cycle
//     (LSB entry first) to consecutive bank addresses. Once every page has
//     been written, load_done_o rises and lookups are enabled.
//   * Lookup side: in READY, each accepted request becomes a read cycle on the
//     bank. The result comes back with a fixed 2-cycle latency, one request
//     per cycle, in order.
//
// Ports
//   sys_clk, sys_rst      clock, synchronous active-high reset
//   start_load_i          pulse: begin/restart a full LUT load
//   load_word_i/valid_i   packed LUT word stream (load_ready_o = ready)
//   load_done_o           level: bank fully loaded, lookups enabled
//   lookup_req_i/addr_i   lookup request (lookup_ready_o = accepted)
//   lookup_valid_o/data_o lookup response, data gated to 0 when not valid
//   mem_*_o / mem_read_page_i  memory bank interface (outputs registered)
// ---------------------------------------------------------------------------
module ib_lut_loader #(
  parameter int QUAN_SIZE      = 3,
  parameter int PAGE_NUM       = 16,
  parameter int ADDR_BITWIDTH  = 4,
  parameter int ENTRY_PER_WORD = 4
) (
  input  logic                                sys_clk,
  input  logic                                sys_rst,
  input  logic                                start_load_i,
  input  logic [QUAN_SIZE*ENTRY_PER_WORD-1:0] load_word_i,
  input  logic                                load_valid_i,
  output logic                                load_ready_o,
  output logic                                load_done_o,
  input  logic                                lookup_req_i,
  input  logic [ADDR_BITWIDTH-1:0]            lookup_addr_i,
  output logic                                lookup_ready_o,
  output logic                                lookup_valid_o,
  output logic [QUAN_SIZE-1:0]                lookup_data_o,
  output logic [QUAN_SIZE-1:0]                mem_write_data_o,
  output logic [ADDR_BITWIDTH-1:0]            mem_addr_o,
  output logic                                mem_we_o,
  input  logic [QUAN_SIZE-1:0]                mem_read_page_i
);

  localparam int WORD_W   = QUAN_SIZE * ENTRY_PER_WORD;
  localparam int WORD_NUM = PAGE_NUM / ENTRY_PER_WORD;
  // One extra bit so the terminal compare against PAGE_NUM never wraps.
  localparam int CNT_W    = ADDR_BITWIDTH + 1;
  localparam int REM_W    = $clog2(ENTRY_PER_WORD + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [CNT_W-1:0]         r_waddr;      // next bank address to write
  logic [CNT_W-1:0]         r_words;      // words accepted in this load
  logic [REM_W-1:0]         r_rem;        // entries still waiting in r_buf
  logic [WORD_W-1:0]        r_buf;        // word being serialised, LSB entry next
  logic                     r_mem_we;
  logic [ADDR_BITWIDTH-1:0] r_mem_addr;
  logic [QUAN_SIZE-1:0]     r_mem_wdata;
  logic                     r_rd_issued;  // read cycle on the bank this cycle
  logic                     r_rsp_valid;  // bank read data valid this cycle

  logic w_load_ready;
  logic w_lookup_ready;
  logic w_load_done;
  logic w_load_complete;
  logic w_issue;
  logic w_word_accept;
  logic w_lookup_accept;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesised registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // The last write (address PAGE_NUM-1) has been issued once the counter
  // reaches PAGE_NUM; READY follows on the next edge.
  assign w_load_complete = (r_state == LOAD) && (r_waddr == CNT_W'(PAGE_NUM));

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    if (start_load_i)         w_next_state = LOAD;
    else if (w_load_complete) w_next_state = READY;
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_load_ready   = 1'b0;
    w_lookup_ready = 1'b0;
    w_load_done    = 1'b0;
    case (r_state)
      LOAD: begin
        // Accept a new word while the last buffered entry is being issued,
        // which keeps back-to-back words writing one entry per cycle.
        w_load_ready = (r_rem <= REM_W'(1)) && (r_words < CNT_W'(WORD_NUM));
      end
      READY: begin
        w_lookup_ready = !start_load_i;
        w_load_done    = 1'b1;
      end
      default: ;
    endcase
  end

  // A restart discards the buffered word, so nothing is issued or accepted on
  // the start edge itself.
  assign w_issue         = (r_state == LOAD) && !start_load_i && (r_rem != '0);
  assign w_word_accept   = load_valid_i && w_load_ready && !start_load_i;
  assign w_lookup_accept = lookup_req_i && w_lookup_ready;

  // -------------------------------------------------------------------------
  // Datapath: serialiser, address counter, memory bus, lookup pipeline
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_waddr     <= '0;
      r_words     <= '0;
      r_rem       <= '0;
      r_buf       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_issued <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      // Lookups already in flight complete regardless of a restart; their
      // bank reads happen before any write of the new load can be issued.
      r_rsp_valid <= r_rd_issued;
      r_rd_issued <= w_lookup_accept;
      r_mem_we    <= w_issue;

      if (start_load_i) begin
        r_waddr <= '0;
        r_words <= '0;
        r_rem   <= '0;
        r_buf   <= '0;
      end else begin
        if (w_issue) begin
          r_mem_addr  <= r_waddr[ADDR_BITWIDTH-1:0];
          r_mem_wdata <= r_buf[QUAN_SIZE-1:0];
          r_buf       <= r_buf >> QUAN_SIZE;
          r_rem       <= r_rem - 1'b1;
          r_waddr     <= r_waddr + 1'b1;
        end
        // A word accepted together with the last entry's issue overrides the
        // buffer update above; the last entry was already taken from r_buf.
        if (w_word_accept) begin
          r_buf   <= load_word_i;
          r_rem   <= REM_W'(ENTRY_PER_WORD);
          r_words <= r_words + 1'b1;
        end
      end

      // Lookups only happen in READY, so they never compete with writes.
      if (w_lookup_accept) r_mem_addr <= lookup_addr_i;
    end
  end

  assign load_ready_o     = w_load_ready;
  assign load_done_o      = w_load_done;
  assign lookup_ready_o   = w_lookup_ready;
  assign lookup_valid_o   = r_rsp_valid;
  assign lookup_data_o    = r_rsp_valid ? mem_read_page_i : '0;
  assign mem_we_o         = r_mem_we;
  assign mem_addr_o       = r_mem_addr;
  assign mem_write_data_o = r_mem_wdata;

endmodule

// File: tb/tb_ib_lut_loader.sv
// ---------------------------------------------------------------------------
// tb_ib_lut_loader
//
// Self-checking bench for ib_lut_loader. A behavioural model (queue of
// pending entry writes, LUT image array, two-slot lookup pipeline) predicts
// every output each cycle; a compare process checks the DUT on the falling
// edge. Directed scenarios add literal expectations, followed by a randomized
// phase. A simple single-port memory model stands in for the bank.
// ---------------------------------------------------------------------------
module tb_ib_lut_loader;

  localparam int Q    = 3;
  localparam int PN   = 16;
  localparam int AW   = 4;
  localparam int EPW  = 4;
  localparam int WW   = Q * EPW;
  localparam int NW   = PN / EPW;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          start_load_i = 1'b0;
  logic [WW-1:0] load_word_i = '0;
  logic          load_valid_i = 1'b0;
  logic          load_ready_o;
  logic          load_done_o;
  logic          lookup_req_i = 1'b0;
  logic [AW-1:0] lookup_addr_i = '0;
  logic          lookup_ready_o;
  logic          lookup_valid_o;
  logic [Q-1:0]  lookup_data_o;
  logic [Q-1:0]  mem_write_data_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [Q-1:0]  mem_read_page_i = '0;

  ib_lut_loader #(
    .QUAN_SIZE(Q), .PAGE_NUM(PN), .ADDR_BITWIDTH(AW), .ENTRY_PER_WORD(EPW)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start_load_i(start_load_i),
    .load_word_i(load_word_i), .load_valid_i(load_valid_i),
    .load_ready_o(load_ready_o), .load_done_o(load_done_o),
    .lookup_req_i(lookup_req_i), .lookup_addr_i(lookup_addr_i),
    .lookup_ready_o(lookup_ready_o), .lookup_valid_o(lookup_valid_o),
    .lookup_data_o(lookup_data_o), .mem_write_data_o(mem_write_data_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_read_page_i(mem_read_page_i)
  );

  always #5 sys_clk = ~sys_clk;

  // -------------------------------------------------------------------------
  // Memory bank: synchronous write, registered read only when not writing.
  // -------------------------------------------------------------------------
  logic [Q-1:0] bank [PN];
  initial for (int i = 0; i < PN; i++) bank[i] = '0;
  always @(posedge sys_clk) begin
    if (mem_we_o) bank[mem_addr_o] <= mem_write_data_o;
    else          mem_read_page_i  <= bank[mem_addr_o];
  end

  // -------------------------------------------------------------------------
  // Checking infrastructure
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

  // -------------------------------------------------------------------------
  // Behavioural model
  // -------------------------------------------------------------------------
  typedef struct packed { logic [AW-1:0] a; logic [Q-1:0] d; } wr_t;
  wr_t          wq[$];          // entry writes still to be issued
  wr_t          m_w;
  bit           m_loading = 0;
  bit           m_loaded  = 0;
  int           m_words   = 0;
  int           m_issued  = 0;
  logic [Q-1:0] img [PN];       // what the bank should hold
  logic         e_we = 0;
  logic [AW-1:0] e_addr = '0;
  logic [Q-1:0] e_wdata = '0;
  logic         p1_v = 0;
  logic [AW-1:0] p1_a = '0;
  logic         e_lv = 0;
  logic [Q-1:0] e_ld = '0;
  bit           acc_w, acc_l;

  initial for (int i = 0; i < PN; i++) img[i] = '0;

  function automatic bit exp_load_ready();
    return m_loading && (wq.size() <= 1) && (m_words < NW);
  endfunction

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      wq.delete();
      m_loading = 0; m_loaded = 0; m_words = 0; m_issued = 0;
      e_we = 0; e_addr = '0; e_wdata = '0;
      p1_v = 0; p1_a = '0; e_lv = 0; e_ld = '0;
    end else begin
      acc_w = load_valid_i && exp_load_ready() && !start_load_i;
      acc_l = lookup_req_i && m_loaded && !start_load_i;
      e_lv  = p1_v;
      e_ld  = p1_v ? img[p1_a] : '0;
      p1_v  = acc_l;
      p1_a  = lookup_addr_i;
      e_we  = 0;
      if (start_load_i) begin
        wq.delete();
        m_words = 0; m_issued = 0; m_loading = 1; m_loaded = 0;
      end else if (m_loading) begin
        if (m_issued == PN) begin
          m_loading = 0; m_loaded = 1;
        end else begin
          if (wq.size() > 0) begin
            m_w = wq.pop_front();
            e_we = 1; e_addr = m_w.a; e_wdata = m_w.d;
            img[m_w.a] = m_w.d;
            m_issued++;
          end
          if (acc_w) begin
            for (int k = 0; k < EPW; k++)
              wq.push_back(wr_t'({AW'(m_words * EPW + k), load_word_i[k*Q +: Q]}));
            m_words++;
          end
        end
      end
      if (acc_l) e_addr = lookup_addr_i;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge sys_clk) begin
    if (chk_en) begin
      check("load_ready",   32'(load_ready_o),     32'(exp_load_ready()));
      check("load_done",    32'(load_done_o),      32'(m_loaded));
      check("lookup_ready", 32'(lookup_ready_o),   32'(m_loaded && !start_load_i));
      check("mem_we",       32'(mem_we_o),         32'(e_we));
      check("mem_addr",     32'(mem_addr_o),       32'(e_addr));
      check("mem_wdata",    32'(mem_write_data_o), 32'(e_wdata));
      check("lookup_valid", 32'(lookup_valid_o),   32'(e_lv));
      check("lookup_data",  32'(lookup_data_o),    32'(e_ld));
    end
  end

  // -------------------------------------------------------------------------
  // Monitors for the directed literal checks
  // -------------------------------------------------------------------------
  typedef struct { logic [AW-1:0] a; logic [Q-1:0] d; int c; } log_t;
  log_t wlog[$];
  log_t llog[$];
  int   done_cyc  = -1;
  bit   prev_done = 0;

  always @(negedge sys_clk) begin
    if (mem_we_o) wlog.push_back('{a: mem_addr_o, d: mem_write_data_o, c: cyc_cnt});
    if (lookup_valid_o) llog.push_back('{a: '0, d: lookup_data_o, c: cyc_cnt});
    if (load_done_o && !prev_done) done_cyc = cyc_cnt;
    prev_done = load_done_o;
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_start();
    start_load_i = 1'b1;
    cyc();
    start_load_i = 1'b0;
  endtask

  // Present a word until it is accepted, then idle for 'gap' cycles.
  task automatic send_word(input logic [WW-1:0] w, input int gap);
    int n;
    n = 0;
    load_valid_i = 1'b1;
    load_word_i  = w;
    while (!load_ready_o && n < 50) begin
      cyc();
      n++;
    end
    if (n >= 50) check("load_ready_timeout", 32'(load_ready_o), 32'd1);
    cyc();
    load_valid_i = 1'b0;
    repeat (gap) cyc();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!load_done_o && n < 100) begin
      cyc();
      n++;
    end
    if (n >= 100) check("load_done_timeout", 32'(load_done_o), 32'd1);
  endtask

  // Test words; entries are taken 3 bits at a time from the LSB, so
  // 0x210 -> 0,2,0,1  0x543 -> 3,0,5,2  0x076 -> 6,6,1,0  0x321 -> 1,4,4,1.
  logic [WW-1:0] words [NW];
  logic [Q-1:0]  lit   [PN];

  task automatic check_load_log(input int base, input string tag);
    check({tag, "_count"}, 32'(wlog.size() - base), 32'(PN));
    if (wlog.size() - base >= PN) begin
      for (int i = 0; i < PN; i++) begin
        check({tag, "_addr"}, 32'(wlog[base+i].a), 32'(i));
        check({tag, "_data"}, 32'(wlog[base+i].d), 32'(lit[i]));
      end
      check({tag, "_done_cycle"}, 32'(done_cyc), 32'(wlog[base+PN-1].c + 1));
    end
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    int ns;
    int n;
    words = '{12'h210, 12'h543, 12'h076, 12'h321};
    lit   = '{3'd0, 3'd2, 3'd0, 3'd1, 3'd3, 3'd0, 3'd5, 3'd2,
              3'd6, 3'd6, 3'd1, 3'd0, 3'd1, 3'd4, 3'd4, 3'd1};

    sys_rst = 1'b1;
    repeat (3) cyc();
    chk_en = 1'b1;
    // Reset state
    check("rst_load_ready", 32'(load_ready_o), 32'd0);
    check("rst_load_done",  32'(load_done_o),  32'd0);
    check("rst_mem_we",     32'(mem_we_o),     32'd0);
    check("rst_mem_addr",   32'(mem_addr_o),   32'd0);
    sys_rst = 1'b0;
    cyc();

    // 1) Back-to-back full load
    wlog.delete(); done_cyc = -1;
    pulse_start();
    for (int i = 0; i < NW; i++) send_word(words[i], 0);
    check("b2b_ready_after_last", 32'(load_ready_o), 32'd0);
    wait_done();
    repeat (2) cyc();
    check_load_log(0, "b2b");
    if (wlog.size() >= PN)
      check("b2b_continuous", 32'(wlog[PN-1].c - wlog[0].c), 32'(PN - 1));

    // 2) Lookup latency and throughput
    llog.delete();
    ns = cyc_cnt;
    lookup_req_i = 1'b1;
    lookup_addr_i = 4'd5;  cyc();
    lookup_addr_i = 4'd6;  cyc();
    lookup_addr_i = 4'd15; cyc();
    lookup_req_i = 1'b0;
    repeat (5) cyc();
    check("lk_count", 32'(llog.size()), 32'd3);
    if (llog.size() == 3) begin
      check("lk0_cycle", 32'(llog[0].c), 32'(ns + 2));
      check("lk1_cycle", 32'(llog[1].c), 32'(ns + 3));
      check("lk2_cycle", 32'(llog[2].c), 32'(ns + 4));
      check("lk0_data",  32'(llog[0].d), 32'd0);
      check("lk1_data",  32'(llog[1].d), 32'd5);
      check("lk2_data",  32'(llog[2].d), 32'd1);
    end

    // 3) Bubbled load with lookup requests during LOAD
    wlog.delete(); llog.delete(); done_cyc = -1;
    pulse_start();
    lookup_req_i = 1'b1;
    for (int i = 0; i < NW; i++) begin
      lookup_addr_i = AW'($urandom_range(0, PN - 1));
      send_word(words[i], 2 + i);
    end
    lookup_req_i = 1'b0;
    wait_done();
    repeat (2) cyc();
    check_load_log(0, "bub");
    if (wlog.size() >= PN)
      check("bub_has_gaps", 32'(wlog[PN-1].c - wlog[0].c > PN - 1), 32'd1);
    check("lk_during_load", 32'(llog.size()), 32'd0);

    // 4) Restart mid-load after 6 entries
    wlog.delete(); done_cyc = -1;
    pulse_start();
    load_valid_i = 1'b1;
    load_word_i  = 12'hfff;
    n = 0;
    while (wlog.size() < 6 && n < 50) begin
      cyc();
      n++;
    end
    check("restart_reached_6", 32'(wlog.size() >= 6), 32'd1);
    load_valid_i = 1'b0;
    pulse_start();
    ns = wlog.size();
    for (int i = 0; i < NW; i++) send_word(words[i], 0);
    wait_done();
    repeat (2) cyc();
    check_load_log(ns, "rst_ld");

    // 5) Reset mid-load
    pulse_start();
    send_word(words[0], 0);
    cyc();
    sys_rst = 1'b1;
    cyc();
    check("mrst_mem_we",     32'(mem_we_o),         32'd0);
    check("mrst_mem_addr",   32'(mem_addr_o),       32'd0);
    check("mrst_mem_wdata",  32'(mem_write_data_o), 32'd0);
    check("mrst_load_ready", 32'(load_ready_o),     32'd0);
    check("mrst_lk_valid",   32'(lookup_valid_o),   32'd0);
    sys_rst = 1'b0;
    repeat (3) cyc();

    // 6) start_load_i coincident with a lookup in READY
    pulse_start();
    for (int i = 0; i < NW; i++) send_word(words[i], 0);
    wait_done();
    cyc();
    llog.delete();
    lookup_req_i = 1'b1; lookup_addr_i = 4'd6;
    cyc();
    lookup_addr_i = 4'd14;
    start_load_i = 1'b1;
    cyc();
    start_load_i = 1'b0; lookup_req_i = 1'b0;
    repeat (4) cyc();
    check("coinc_lk_count", 32'(llog.size()), 32'd1);
    if (llog.size() == 1) check("coinc_lk_data", 32'(llog[0].d), 32'd5);
    check("coinc_in_load", 32'(load_done_o), 32'd0);
    for (int i = 0; i < NW; i++) send_word(words[i], 0);
    wait_done();

    // 7) Randomized traffic
    for (int t = 0; t < 4000; t++) begin
      sys_rst       = ($urandom_range(0, 599) == 0);
      start_load_i  = ($urandom_range(0, 79) == 0);
      load_valid_i  = ($urandom_range(0, 9) < 7);
      load_word_i   = WW'($urandom);
      lookup_req_i  = ($urandom_range(0, 1) == 1);
      lookup_addr_i = AW'($urandom);
      cyc();
    end
    sys_rst = 1'b0; start_load_i = 1'b0; load_valid_i = 1'b0; lookup_req_i = 1'b0;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc_cnt);
    $fatal(1, "watchdog");
  end

endmodule
